// File: rtl/eth_phy_rx_block_sync_mc.sv
// Multi-lane 64b/66b RX block synchroniser: each lane barrel-aligns raw GT frames,
// hunts for the sync-header boundary, holds lock and counts lock-loss events.
module eth_phy_rx_block_sync_mc #(
  parameter int CHANNELS      = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int HDR_WIDTH     = 2,
  parameter int FRAME_WIDTH   = 66,
  parameter int BIT_REVERSE   = 0,
  parameter int SH_WINDOW     = 64,
  parameter int INVALID_LIMIT = 16,
  parameter int SLIP_WAIT     = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CHANNELS*FRAME_WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]             in_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0]  out_data,
  output logic [CHANNELS*HDR_WIDTH-1:0]   out_hdr,
  output logic [CHANNELS-1:0]             out_valid,
  output logic [CHANNELS-1:0]             block_lock,
  output logic                            all_lock,
  output logic [CHANNELS*7-1:0]           slip_offset,
  output logic [CHANNELS*8-1:0]           lock_loss_count
);
  localparam int SH_W  = $clog2(SH_WINDOW);
  localparam int INV_W = (INVALID_LIMIT > 1) ? $clog2(INVALID_LIMIT) : 1;
  localparam logic [SH_W-1:0]  SH_LAST    = SH_W'(SH_WINDOW - 1);
  localparam logic [INV_W-1:0] INV_LAST   = INV_W'(INVALID_LIMIT - 1);
  localparam logic [3:0]       WAIT_LAST  = 4'(SLIP_WAIT - 1);
  localparam logic [6:0]       OFFSET_MAX = 7'(FRAME_WIDTH - 1);

  typedef enum logic [1:0] {PRIME, TEST, SLIP, LOCKED} state_t;

  logic [CHANNELS-1:0] lock_d;
  logic                allLock_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    state_t                  state_q;
    logic [FRAME_WIDTH-1:0]  prevFrame_q;
    logic [FRAME_WIDTH-1:0]  frameRaw;
    logic [FRAME_WIDTH-1:0]  frame;
    logic [FRAME_WIDTH-1:0]  aligned;
    logic [2*FRAME_WIDTH-1:0] window;
    logic [6:0]              offset_q;
    logic [6:0]              offsetInc;
    logic [SH_W-1:0]         shCnt_q;
    logic [INV_W-1:0]        invCnt_q;
    logic [3:0]              waitCnt_q;
    logic [7:0]              lossCnt_q;
    logic [DATA_WIDTH-1:0]   outData_q;
    logic [HDR_WIDTH-1:0]    outHdr_q;
    logic                    outValid_q;
    logic                    lock_q;
    logic                    hdrValid;
    logic                    lockSet;
    logic                    lockLoss;

    // The newest frame sits above the previous one, so an offset k selects a
    // block that starts k bits into the older frame.
    always_comb begin
      frameRaw = in_data[g*FRAME_WIDTH +: FRAME_WIDTH];
      frame    = frameRaw;
      if (BIT_REVERSE != 0) begin
        for (int b = 0; b < FRAME_WIDTH; b++) frame[b] = frameRaw[FRAME_WIDTH-1-b];
      end
      window    = {frame, prevFrame_q};
      aligned   = window[offset_q +: FRAME_WIDTH];
      hdrValid  = (aligned[HDR_WIDTH-1:0] == 2'b01) || (aligned[HDR_WIDTH-1:0] == 2'b10);
      offsetInc = (offset_q == OFFSET_MAX) ? 7'd0 : offset_q + 7'd1;
      lockSet   = in_valid[g] && (state_q == TEST) && hdrValid && (shCnt_q == SH_LAST);
      lockLoss  = in_valid[g] && (state_q == LOCKED) && !hdrValid && (invCnt_q == INV_LAST);
      lock_d[g] = lockSet | (lock_q & ~lockLoss);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= PRIME;
        prevFrame_q <= '0;
        offset_q    <= '0;
        shCnt_q     <= '0;
        invCnt_q    <= '0;
        waitCnt_q   <= '0;
        lossCnt_q   <= '0;
        outData_q   <= '0;
        outHdr_q    <= '0;
        outValid_q  <= 1'b0;
        lock_q      <= 1'b0;
      end else begin
        outValid_q <= 1'b0;
        lock_q     <= lock_d[g];
        if (in_valid[g]) begin
          prevFrame_q <= frame;
          if (state_q != PRIME) begin
            outValid_q <= 1'b1;
            outData_q  <= aligned[FRAME_WIDTH-1:HDR_WIDTH];
            outHdr_q   <= aligned[HDR_WIDTH-1:0];
          end
          case (state_q)
            PRIME: state_q <= TEST;
            TEST: begin
              if (!hdrValid) begin
                offset_q  <= offsetInc;
                shCnt_q   <= '0;
                invCnt_q  <= '0;
                waitCnt_q <= '0;
                state_q   <= (SLIP_WAIT == 0) ? TEST : SLIP;
              end else if (lockSet) begin
                shCnt_q  <= '0;
                invCnt_q <= '0;
                state_q  <= LOCKED;
              end else begin
                shCnt_q <= shCnt_q + 1'b1;
              end
            end
            SLIP: begin
              if (waitCnt_q == WAIT_LAST) state_q <= TEST;
              else waitCnt_q <= waitCnt_q + 4'd1;
            end
            LOCKED: begin
              // A loss on the last frame of a window takes priority over the window reset.
              if (lockLoss) begin
                if (lossCnt_q != 8'hFF) lossCnt_q <= lossCnt_q + 8'd1;
                offset_q  <= offsetInc;
                shCnt_q   <= '0;
                invCnt_q  <= '0;
                waitCnt_q <= '0;
                state_q   <= (SLIP_WAIT == 0) ? TEST : SLIP;
              end else if (shCnt_q == SH_LAST) begin
                shCnt_q  <= '0;
                invCnt_q <= '0;
              end else begin
                shCnt_q <= shCnt_q + 1'b1;
                if (!hdrValid) invCnt_q <= invCnt_q + 1'b1;
              end
            end
            default: state_q <= PRIME;
          endcase
        end
      end
    end

    assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = outData_q;
    assign out_hdr[g*HDR_WIDTH +: HDR_WIDTH]    = outHdr_q;
    assign out_valid[g]                         = outValid_q;
    assign block_lock[g]                        = lock_q;
    assign slip_offset[g*7 +: 7]                = offset_q;
    assign lock_loss_count[g*8 +: 8]            = lossCnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) allLock_q <= 1'b0;
    else        allLock_q <= &lock_d;
  end

  assign all_lock = allLock_q;

endmodule

// File: tb/tb_eth_phy_rx_block_sync_mc.sv
// Directed bench for the multi-lane block synchroniser: builds shifted 66b bitstreams
// per lane and checks lock acquisition, slipping, lock loss, idle hold and async reset.
module tb_eth_phy_rx_block_sync_mc;
  localparam int CH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH*66-1:0]  inData;
  logic [CH-1:0]     inValid;
  logic [CH*64-1:0]  outData;
  logic [CH*2-1:0]   outHdr;
  logic [CH-1:0]     outValid;
  logic [CH-1:0]     blockLock;
  logic              allLock;
  logic [CH*7-1:0]   slipOffset;
  logic [CH*8-1:0]   lockLossCount;

  int errors = 0;
  int checks = 0;
  int shiftAmt [CH];
  int frameIdx [CH];
  bit badHdr [CH][4096];

  eth_phy_rx_block_sync_mc dut (
    .clk(clk), .rst_n(rst_n), .in_data(inData), .in_valid(inValid),
    .out_data(outData), .out_hdr(outHdr), .out_valid(outValid),
    .block_lock(blockLock), .all_lock(allLock), .slip_offset(slipOffset),
    .lock_loss_count(lockLossCount)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] payloadOf(int lane, int n);
    logic [63:0] s;
    s = ((64'(n) + 64'd1) * 64'h9E3779B97F4A7C15) ^ (64'(lane + 1) << 40);
    s = s ^ (s << 13);
    s = s ^ (s >> 7);
    s = s ^ (s << 17);
    return s;
  endfunction

  function automatic logic [65:0] blockOf(int lane, int n);
    logic [1:0] hdr;
    if (n < 0) return '0;
    hdr = (n < 4096 && badHdr[lane][n]) ? 2'b00 : 2'b01;
    return {payloadOf(lane, n), hdr};
  endfunction

  // Frame m carries stream bits [66m +: 66]; blocks start shiftAmt bits into the stream.
  function automatic logic [65:0] frameOf(int lane, int m);
    logic [131:0] pair;
    pair = {blockOf(lane, m), blockOf(lane, m - 1)};
    return pair[66 - shiftAmt[lane] +: 66];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] valid);
    for (int l = 0; l < CH; l++) begin
      if (valid[l]) inData[l*66 +: 66] = frameOf(l, frameIdx[l]);
      else          inData[l*66 +: 66] = 66'({$urandom(), $urandom(), $urandom()});
    end
    inValid = valid;
    @(posedge clk);
    #1;
    for (int l = 0; l < CH; l++) if (valid[l]) frameIdx[l]++;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_outValid"}, 64'(outValid), 64'd0);
    checkOutput({tag, "_blockLock"}, 64'(blockLock), 64'd0);
    checkOutput({tag, "_allLock"}, 64'(allLock), 64'd0);
    checkOutput({tag, "_slipOffset"}, 64'(slipOffset), 64'd0);
    checkOutput({tag, "_lossCount"}, 64'(lockLossCount), 64'd0);
    checkOutput({tag, "_outDataAny"}, 64'(|outData), 64'd0);
    checkOutput({tag, "_outHdr"}, 64'(outHdr), 64'd0);
  endtask

  initial begin
    int lastSlip [CH];
    int slipCount [CH];
    int lockFrame [CH];
    logic [6:0] prevOff [CH];
    logic [CH-1:0] prevLock;
    int cur;
    int n0;

    rst_n   = 1'b0;
    inValid = '0;
    inData  = '0;
    for (int l = 0; l < CH; l++) begin
      shiftAmt[l] = 0;
      frameIdx[l] = 0;
    end
    for (int n = 70; n <= 84; n++) badHdr[1][n] = 1'b1;
    for (int n = 130; n <= 145; n++) badHdr[1][n] = 1'b1;
    #12;
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All lanes at offset 0: prime, then 64 tested frames to lock
    applyStimulus(4'hF);
    checkOutput("prime_outValid", 64'(outValid), 64'd0);
    applyStimulus(4'hF);
    checkOutput("first_outValid", 64'(outValid), 64'hF);
    for (int l = 0; l < CH; l++) begin
      checkOutput($sformatf("first_data_l%0d", l), outData[l*64 +: 64], payloadOf(l, 0));
      checkOutput($sformatf("first_hdr_l%0d", l), 64'(outHdr[l*2 +: 2]), 64'd1);
    end
    while (frameIdx[0] < 64) applyStimulus(4'hF);
    checkOutput("lock_before65", 64'(blockLock), 64'd0);
    applyStimulus(4'hF);
    checkOutput("lock_at65", 64'(blockLock), 64'hF);
    checkOutput("allLock_at65", 64'(allLock), 64'd1);
    checkOutput("offset_at65", 64'(slipOffset), 64'd0);
    for (int l = 0; l < CH; l++)
      checkOutput($sformatf("lock_data_l%0d", l), outData[l*64 +: 64], payloadOf(l, 63));

    // Idle cycles hold every lane
    applyStimulus(4'hF);
    checkOutput("idle_pre_outValid", 64'(outValid), 64'hF);
    applyStimulus(4'h0);
    checkOutput("idle1_outValid", 64'(outValid), 64'd0);
    checkOutput("idle1_lock", 64'(blockLock), 64'hF);
    applyStimulus(4'h0);
    checkOutput("idle2_outValid", 64'(outValid), 64'd0);
    checkOutput("idle2_offset", 64'(slipOffset), 64'd0);
    checkOutput("idle2_allLock", 64'(allLock), 64'd1);
    applyStimulus(4'hF);
    checkOutput("idle_post_outValid", 64'(outValid), 64'hF);
    checkOutput("idle_post_data_l0", outData[63:0], payloadOf(0, 65));
    checkOutput("idle_post_data_l3", outData[3*64 +: 64], payloadOf(3, 65));

    // Lane 1: 15 invalid headers in one window, then 16 in the next
    while (frameIdx[1] < 86) applyStimulus(4'hF);
    checkOutput("inv15_lock_l1", 64'(blockLock[1]), 64'd1);
    checkOutput("inv15_hdr_l1", 64'(outHdr[3:2]), 64'd0);
    while (frameIdx[1] < 129) applyStimulus(4'hF);
    checkOutput("window1_end_lock_l1", 64'(blockLock[1]), 64'd1);
    while (frameIdx[1] < 146) applyStimulus(4'hF);
    checkOutput("inv15b_lock_l1", 64'(blockLock[1]), 64'd1);
    checkOutput("inv15b_loss_l1", 64'(lockLossCount[15:8]), 64'd0);
    applyStimulus(4'hF);
    checkOutput("inv16_lock", 64'(blockLock), 64'hD);
    checkOutput("inv16_loss_l1", 64'(lockLossCount[15:8]), 64'd1);
    checkOutput("inv16_offset_l1", 64'(slipOffset[13:7]), 64'd1);
    checkOutput("inv16_offset_l0", 64'(slipOffset[6:0]), 64'd0);
    checkOutput("inv16_allLock", 64'(allLock), 64'd0);
    applyStimulus(4'hF);
    applyStimulus(4'hF);

    // Asynchronous reset between clock edges
    rst_n = 1'b0;
    #2;
    checkResetOutputs("asyncRst");
    @(posedge clk);
    #1;
    shiftAmt[2] = 17;
    shiftAmt[3] = 65;
    for (int l = 0; l < CH; l++) begin
      frameIdx[l] = 0;
      for (int n = 0; n < 4096; n++) badHdr[l][n] = 1'b0;
      lastSlip[l]  = -100;
      slipCount[l] = 0;
      lockFrame[l] = -1;
      prevOff[l]   = '0;
    end
    rst_n = 1'b1;
    applyStimulus(4'hF);
    checkOutput("reprime_outValid", 64'(outValid), 64'd0);

    // Lanes 2 and 3 hunt for shifts of 17 and 65
    prevLock = '0;
    for (int step = 0; step < 3000 && allLock !== 1'b1; step++) begin
      prevLock = blockLock;
      applyStimulus(4'hF);
      cur = frameIdx[0] - 1;
      for (int l = 2; l < CH; l++) begin
        if (slipOffset[l*7 +: 7] != prevOff[l]) begin
          if (slipCount[l] > 0)
            checkOutput($sformatf("slipGap_l%0d", l), 64'((cur - lastSlip[l]) >= 3), 64'd1);
          lastSlip[l] = cur;
          slipCount[l]++;
          prevOff[l] = slipOffset[l*7 +: 7];
        end
        if (blockLock[l] && lockFrame[l] < 0) lockFrame[l] = cur;
      end
      if (cur == 63) checkOutput("hunt_lock01_early", 64'(blockLock[1:0]), 64'd0);
      if (cur == 64) begin
        checkOutput("hunt_lock01_at65", 64'(blockLock[1:0]), 64'd3);
        checkOutput("hunt_allLock_at65", 64'(allLock), 64'd0);
      end
    end
    cur = frameIdx[0] - 1;
    checkOutput("hunt_allLock", 64'(allLock), 64'd1);
    checkOutput("hunt_blockLock", 64'(blockLock), 64'hF);
    checkOutput("hunt_allLock_with_last", 64'(prevLock == 4'hF), 64'd0);
    checkOutput("hunt_slips_l2", 64'(slipCount[2]), 64'd17);
    checkOutput("hunt_slips_l3", 64'(slipCount[3]), 64'd65);
    checkOutput("hunt_offset_l2", 64'(slipOffset[2*7 +: 7]), 64'd17);
    checkOutput("hunt_offset_l3", 64'(slipOffset[3*7 +: 7]), 64'd65);
    checkOutput("hunt_lockTime_l2", 64'(lockFrame[2] - lastSlip[2]), 64'd66);
    checkOutput("hunt_lockTime_l3", 64'(lockFrame[3] - lastSlip[3]), 64'd66);
    checkOutput("hunt_loss", 64'(lockLossCount), 64'd0);
    for (int l = 2; l < CH; l++) begin
      checkOutput($sformatf("hunt_data_l%0d", l), outData[l*64 +: 64], payloadOf(l, cur - 1));
      checkOutput($sformatf("hunt_hdr_l%0d", l), 64'(outHdr[l*2 +: 2]), 64'd1);
    end

    // Lane 3 loses lock at offset 65 and must wrap to 0
    for (int k = 0; k < 64 && ((frameIdx[3] - 1 - lockFrame[3]) % 64) != 0; k++) applyStimulus(4'hF);
    n0 = frameIdx[3];
    for (int n = n0; n < n0 + 16 && n < 4096; n++) badHdr[3][n] = 1'b1;
    repeat (16) applyStimulus(4'hF);
    checkOutput("wrap_hold_lock_l3", 64'(blockLock[3]), 64'd1);
    checkOutput("wrap_hold_offset_l3", 64'(slipOffset[3*7 +: 7]), 64'd65);
    applyStimulus(4'hF);
    checkOutput("wrap_lock", 64'(blockLock), 64'h7);
    checkOutput("wrap_offset_l3", 64'(slipOffset[3*7 +: 7]), 64'd0);
    checkOutput("wrap_loss_l3", 64'(lockLossCount[3*8 +: 8]), 64'd1);
    checkOutput("wrap_allLock", 64'(allLock), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
